cpu_csr_access_ctl: RTL and testbench

Sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) in front of the CPU CSR register file. It accepts one request at a time from the execute stage and drives the CSR file's registered read port, then its write port. It computes the read-modify-write value, enforces read-only CSR and write-suppression rules, and returns the old CSR value to the pipeline through a valid/ready response.

---
 rtl/cpu_csr_access_ctl_pkg.sv | 23 ++
 rtl/cpu_csr_access_ctl_rmw.sv | 21 ++
 rtl/cpu_csr_access_ctl.sv | 117 +++++++++++
 tb/tb_cpu_csr_access_ctl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_csr_access_ctl_pkg.sv
// rtl/cpu_csr_access_ctl_pkg.sv - shared CSR types and Zicsr decode helpers
package cpu_csr_access_ctl_pkg;

    typedef logic [11:0] csr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        CSR_OP_RW = 2'b01,
        CSR_OP_RS = 2'b10,
        CSR_OP_RC = 2'b11
    } csr_op_t;

    // CSRRW with rd=x0 must not read (no read side effects)
    function automatic logic csr_do_read(input csr_op_t op, input logic rd_zero);
        return !(op == CSR_OP_RW && rd_zero);
    endfunction

    // CSRRS/CSRRC with a zero source must not write
    function automatic logic csr_do_write(input csr_op_t op, input logic src_zero);
        return (op == CSR_OP_RW) || !src_zero;
    endfunction

endpackage

// File: rtl/cpu_csr_access_ctl_rmw.sv
// rtl/cpu_csr_access_ctl_rmw.sv - read-modify-write value for CSRRW/CSRRS/CSRRC
module cpu_csr_rmw
    import cpu_csr_access_ctl_pkg::*;
(
    input  csr_op_t op,
    input  word_t   old,
    input  word_t   operand,
    output word_t   new_value
);

    always_comb begin
        new_value = old;
        case (op)
            CSR_OP_RW: new_value = operand;
            CSR_OP_RS: new_value = old | operand;
            CSR_OP_RC: new_value = old & ~operand;
            default:   new_value = old;
        endcase
    end

endmodule

// File: rtl/cpu_csr_access_ctl.sv
// rtl/cpu_csr_access_ctl.sv - Zicsr request sequencer in front of the CSR register file
module cpu_csr_access_ctl
    import cpu_csr_access_ctl_pkg::*;
#(
    parameter bit RO_CHECK = 1'b1
) (
    input  logic    clk_i,
    input  logic    reset_ni,
    input  logic    req_valid_i,
    output logic    req_ready_o,
    input  csr_op_t req_op_i,
    input  csr_t    req_addr_i,
    input  word_t   req_operand_i,
    input  logic    req_src_zero_i,
    input  logic    req_rd_zero_i,
    output logic    resp_valid_o,
    input  logic    resp_ready_i,
    output word_t   resp_data_o,
    output logic    resp_illegal_o,
    output csr_t    csr_read_addr_o,
    output logic    csr_read_enable_o,
    input  word_t   csr_read_data_i,
    output csr_t    csr_write_addr_o,
    output word_t   csr_write_data_o,
    output logic    csr_write_enable_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0] state;
    csr_op_t    op_q;
    csr_t       addr_q;
    word_t      operand_q;
    logic       src_zero_q;
    logic       rd_zero_q;
    word_t      data_q;
    logic       illegal_q;

    logic       accept;
    logic       in_read;
    logic       in_illegal;
    logic       do_read;
    logic       do_write;
    word_t      old_value;
    word_t      new_value;

    assign req_ready_o = reset_ni && (state == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;

    // Flags for the accept-edge transition come from the inputs being latched
    assign in_read    = csr_do_read(req_op_i, req_rd_zero_i);
    assign in_illegal = RO_CHECK && csr_do_write(req_op_i, req_src_zero_i)
                        && (req_addr_i[11:10] == 2'b11);

    assign do_read   = csr_do_read(op_q, rd_zero_q);
    assign do_write  = csr_do_write(op_q, src_zero_q);
    assign old_value = do_read ? csr_read_data_i : '0;

    cpu_csr_rmw u_rmw (
        .op        (op_q),
        .old       (old_value),
        .operand   (operand_q),
        .new_value (new_value)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= S_IDLE;
            op_q       <= CSR_OP_RW;
            addr_q     <= '0;
            operand_q  <= '0;
            src_zero_q <= 1'b0;
            rd_zero_q  <= 1'b0;
            data_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= req_op_i;
                        addr_q     <= req_addr_i;
                        operand_q  <= req_operand_i;
                        src_zero_q <= req_src_zero_i;
                        rd_zero_q  <= req_rd_zero_i;
                        data_q     <= '0;
                        illegal_q  <= in_illegal;
                        if (in_illegal)   state <= S_RESP;
                        else if (in_read) state <= S_READ;
                        else              state <= S_WRITE;
                    end
                end
                S_READ:  state <= S_WRITE;
                S_WRITE: begin
                    data_q <= old_value;
                    state  <= S_RESP;
                end
                default: begin
                    if (resp_ready_i) state <= S_IDLE;
                end
            endcase
        end
    end

    assign csr_read_enable_o  = (state == S_READ);
    assign csr_read_addr_o    = (state == S_READ) ? addr_q : '0;
    assign csr_write_enable_o = (state == S_WRITE) && do_write;
    assign csr_write_addr_o   = (state == S_WRITE) ? addr_q : '0;
    assign csr_write_data_o   = (state == S_WRITE) ? new_value : '0;

    assign resp_valid_o   = (state == S_RESP);
    assign resp_data_o    = data_q;
    assign resp_illegal_o = illegal_q;

endmodule

// File: tb/tb_cpu_csr_access_ctl.sv
// tb/tb_cpu_csr_access_ctl.sv - scoreboard bench for the Zicsr access sequencer
module tb_cpu_csr_access_ctl;
    import cpu_csr_access_ctl_pkg::*;

    logic    clk_i = 1'b0;
    logic    reset_ni = 1'b0;
    logic    req_valid_i = 1'b0;
    logic    req_ready_o;
    csr_op_t req_op_i = CSR_OP_RW;
    csr_t    req_addr_i = '0;
    word_t   req_operand_i = '0;
    logic    req_src_zero_i = 1'b0;
    logic    req_rd_zero_i = 1'b0;
    logic    resp_valid_o;
    logic    resp_ready_i = 1'b1;
    word_t   resp_data_o;
    logic    resp_illegal_o;
    csr_t    csr_read_addr_o;
    logic    csr_read_enable_o;
    word_t   csr_read_data_i = '0;
    csr_t    csr_write_addr_o;
    word_t   csr_write_data_o;
    logic    csr_write_enable_o;

    cpu_csr_access_ctl dut (
        .clk_i              (clk_i),
        .reset_ni           (reset_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_op_i           (req_op_i),
        .req_addr_i         (req_addr_i),
        .req_operand_i      (req_operand_i),
        .req_src_zero_i     (req_src_zero_i),
        .req_rd_zero_i      (req_rd_zero_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_data_o        (resp_data_o),
        .resp_illegal_o     (resp_illegal_o),
        .csr_read_addr_o    (csr_read_addr_o),
        .csr_read_enable_o  (csr_read_enable_o),
        .csr_read_data_i    (csr_read_data_i),
        .csr_write_addr_o   (csr_write_addr_o),
        .csr_write_data_o   (csr_write_data_o),
        .csr_write_enable_o (csr_write_enable_o)
    );

    always #5 clk_i = ~clk_i;

    localparam csr_t MTVEC    = 12'h305;
    localparam csr_t MIE      = 12'h304;
    localparam csr_t MSCRATCH = 12'h340;
    localparam csr_t CYCLE    = 12'hC00;
    localparam csr_t TIME     = 12'hC01;
    localparam csr_t MHARTID  = 12'hF14;

    typedef struct {
        word_t data;
        logic  illegal;
        int    lat;
        int    nrd;
        int    nwr;
    } exp_t;

    typedef struct {
        csr_t  addr;
        word_t data;
    } wr_t;

    exp_t  sb[$];
    wr_t   wq[$];
    word_t csr_mem [0:4095];
    word_t ref_mem [0:4095];
    int    n_cmp = 0;
    int    n_err = 0;
    int    reads_seen = 0;
    int    writes_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // CSR register file: registered read port, write port
    always @(posedge clk_i) begin
        if (csr_read_enable_o) csr_read_data_i <= csr_mem[csr_read_addr_o];
        if (csr_write_enable_o) csr_mem[csr_write_addr_o] <= csr_write_data_o;
    end

    always @(negedge clk_i) begin
        if (csr_read_enable_o) reads_seen++;
        if (csr_read_enable_o && csr_write_enable_o) check_eq("rd_wr_excl", 1, 0);
        if (csr_write_enable_o) begin
            writes_seen++;
            if (wq.size() == 0) begin
                check_eq("wr_unexpected", 1, 0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check_eq("wr_addr", 32'(csr_write_addr_o), 32'(w.addr));
                check_eq("wr_data", csr_write_data_o, w.data);
            end
        end
    end

    task automatic txn(input csr_op_t op, input csr_t addr, input word_t operand,
                       input logic sz, input logic rz, input bit hold);
        exp_t  e;
        exp_t  got;
        word_t old;
        word_t nv;
        logic  drd, dwr, ill;
        int    w;
        int    lat;
        drd = !(op == CSR_OP_RW && rz);
        dwr = (op == CSR_OP_RW) || !sz;
        ill = dwr && (addr[11:10] == 2'b11);
        old = drd ? ref_mem[addr] : 32'h0;
        if (op == CSR_OP_RW)      nv = operand;
        else if (op == CSR_OP_RS) nv = old | operand;
        else                      nv = old & ~operand;
        e.illegal = ill;
        e.data    = ill ? 32'h0 : old;
        e.lat     = ill ? 1 : (drd ? 3 : 2);
        e.nrd     = (!ill && drd) ? 1 : 0;
        e.nwr     = (!ill && dwr) ? 1 : 0;
        if (!ill && dwr) begin
            wq.push_back('{addr: addr, data: nv});
            ref_mem[addr] = nv;
        end
        sb.push_back(e);

        reads_seen = 0;
        writes_seen = 0;
        resp_ready_i   = !hold;
        req_op_i       = op;
        req_addr_i     = addr;
        req_operand_i  = operand;
        req_src_zero_i = sz;
        req_rd_zero_i  = rz;
        req_valid_i    = 1'b1;
        w = 0;
        while (!req_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        if (!req_ready_o) begin
            check_eq("accept_timeout", 0, 1);
            req_valid_i = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;

        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!resp_valid_o && lat < 20);
        if (!resp_valid_o) begin
            check_eq("resp_timeout", 0, 1);
            void'(sb.pop_front());
            resp_ready_i = 1'b1;
            return;
        end
        got = sb.pop_front();
        check_eq("latency", lat, got.lat);
        check_eq("resp_data", resp_data_o, got.data);
        check_eq("resp_illegal", 32'(resp_illegal_o), 32'(got.illegal));
        if (hold) begin
            repeat (5) begin
                @(negedge clk_i);
                check_eq("hold_valid", 32'(resp_valid_o), 1);
                check_eq("hold_data", resp_data_o, got.data);
                check_eq("hold_illegal", 32'(resp_illegal_o), 32'(got.illegal));
                check_eq("hold_req_ready", 32'(req_ready_o), 0);
            end
            resp_ready_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        check_eq("resp_dropped", 32'(resp_valid_o), 0);
        check_eq("read_count", reads_seen, got.nrd);
        check_eq("write_count", writes_seen, got.nwr);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_req_ready"}, 32'(req_ready_o), 0);
        check_eq({pfx, "_resp_valid"}, 32'(resp_valid_o), 0);
        check_eq({pfx, "_resp_illegal"}, 32'(resp_illegal_o), 0);
        check_eq({pfx, "_resp_data"}, resp_data_o, 0);
        check_eq({pfx, "_rd_en"}, 32'(csr_read_enable_o), 0);
        check_eq({pfx, "_wr_en"}, 32'(csr_write_enable_o), 0);
        check_eq({pfx, "_rd_addr"}, 32'(csr_read_addr_o), 0);
        check_eq({pfx, "_wr_addr"}, 32'(csr_write_addr_o), 0);
        check_eq({pfx, "_wr_data"}, csr_write_data_o, 0);
    endtask

    initial begin
        csr_t  rand_addr [4];
        csr_op_t op;
        logic  sz, rz;
        word_t opnd;
        rand_addr[0] = MSCRATCH;
        rand_addr[1] = MIE;
        rand_addr[2] = TIME;
        rand_addr[3] = MTVEC;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = '0;
            ref_mem[i] = '0;
        end
        csr_mem[CYCLE] = 32'h1234_5678;
        ref_mem[CYCLE] = 32'h1234_5678;
        csr_mem[TIME]  = 32'h0BAD_F00D;
        ref_mem[TIME]  = 32'h0BAD_F00D;

        #13;
        check_outputs_zero("reset");
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        #1;
        check_eq("ready_after_reset", 32'(req_ready_o), 1);

        txn(CSR_OP_RW, MTVEC, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
        txn(CSR_OP_RS, MTVEC, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        txn(CSR_OP_RC, MTVEC, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        txn(CSR_OP_RS, CYCLE, 32'h0, 1'b1, 1'b0, 1'b0);
        txn(CSR_OP_RW, MHARTID, 32'h5, 1'b0, 1'b0, 1'b0);
        txn(CSR_OP_RW, MTVEC, 32'h40, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            op   = csr_op_t'(2'($urandom_range(1, 3)));
            sz   = ($urandom_range(0, 3) == 0);
            rz   = ($urandom_range(0, 3) == 0);
            opnd = sz ? 32'h0 : $urandom;
            txn(op, rand_addr[$urandom_range(0, 3)], opnd, sz, rz, ($urandom_range(0, 5) == 0));
        end

        // Reset during READ drops the request without a write
        reads_seen = 0;
        writes_seen = 0;
        req_op_i       = CSR_OP_RS;
        req_addr_i     = MSCRATCH;
        req_operand_i  = 32'h0000_00FF;
        req_src_zero_i = 1'b0;
        req_rd_zero_i  = 1'b0;
        req_valid_i    = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        check_eq("mid_rd_en", 32'(csr_read_enable_o), 1);
        #2;
        reset_ni = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        #1;
        check_eq("ready_after_mid_reset", 32'(req_ready_o), 1);
        check_eq("mid_reset_writes", writes_seen, 0);
        check_eq("mid_reset_mem", csr_mem[MSCRATCH], ref_mem[MSCRATCH]);
        @(posedge clk_i);
        #1;
        txn(CSR_OP_RS, MSCRATCH, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0);

        check_eq("sb_empty", sb.size(), 0);
        check_eq("wq_empty", wq.size(), 0);
        check_eq("final_mtvec", csr_mem[MTVEC], ref_mem[MTVEC]);
        check_eq("final_mscratch", csr_mem[MSCRATCH], ref_mem[MSCRATCH]);
        check_eq("final_mie", csr_mem[MIE], ref_mem[MIE]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
